// File: rtl/board_serializer.sv
// rtl/board_serializer.sv - snapshot board word and shift it out MSB-first with sclk and latch
module board_serializer #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic             in_clk,
    input  logic             in_restart_n,
    input  logic [WIDTH-1:0] in_board,
    input  logic             in_send,
    input  logic             in_auto,
    output logic             out_busy,
    output logic             out_sclk,
    output logic             out_sdata,
    output logic             out_latch,
    output logic             out_done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0] last_sent_q, last_sent_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             phase_q, phase_d;
    logic             busy_q, busy_d;
    logic             sclk_q, sclk_d;
    logic             sdata_q, sdata_d;
    logic             latch_q, latch_d;
    logic             done_q, done_d;

    logic             div_end;
    logic             start;
    logic [WIDTH-1:0] shifted;

    assign out_busy  = busy_q;
    assign out_sclk  = sclk_q;
    assign out_sdata = sdata_q;
    assign out_latch = latch_q;
    assign out_done  = done_q;

    // Next-state logic: divider paces sclk half-periods; data only moves on sclk falling edge
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        last_sent_d = last_sent_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        phase_d     = phase_q;
        busy_d      = busy_q;
        sclk_d      = sclk_q;
        sdata_d     = sdata_q;
        latch_d     = latch_q;
        done_d      = 1'b0;

        div_end = (div_cnt_q == DIV_MAX);
        start   = in_send || (in_auto && (in_board != last_sent_q));
        // Bit bit_cnt+1 of the snapshot lands in the MSB position
        shifted = snap_q << (bit_cnt_q + BW'(1));

        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
                latch_d = 1'b0;
                if (start) begin
                    snap_d    = in_board;
                    sdata_d   = in_board[WIDTH-1];
                    busy_d    = 1'b1;
                    phase_d   = 1'b0;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end else begin
                    div_cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        if (bit_cnt_q != BIT_MAX) begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                            sdata_d   = shifted[WIDTH-1];
                        end else begin
                            sdata_d = 1'b0;
                            latch_d = 1'b1;
                            state_d = LATCH;
                        end
                    end
                end
            end
            LATCH: begin
                if (!div_end) begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end else begin
                    div_cnt_d   = '0;
                    latch_d     = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    last_sent_d = snap_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer silently
    always_ff @(posedge in_clk or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            last_sent_q <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            sclk_q      <= 1'b0;
            sdata_q     <= 1'b0;
            latch_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            last_sent_q <= last_sent_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            sclk_q      <= sclk_d;
            sdata_q     <= sdata_d;
            latch_q     <= latch_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_board_serializer.sv
// tb/tb_board_serializer.sv - directed bench for board_serializer at CLK_DIV 1 and 4
module tb_board_serializer;

    logic        clk;
    logic        rst_n;
    logic [31:0] board;
    logic        send1, auto1, send4, auto4;
    logic [1:0]  busy, sclk, sdata, latch, done;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int e0;
    bit ok;
    logic mon_clr = 1'b0;

    logic [31:0] rx_word [2];
    int rise_cnt [2], latch_cyc [2], done_cnt [2], busy_cyc [2], viol [2];
    int latch_at [2], done_at [2], hi_len [2], hi_min [2], hi_max [2];
    logic prev_sclk [2], prev_sdata [2], prev_latch [2];

    board_serializer #(.WIDTH(32), .CLK_DIV(1)) u1 (
        .in_clk(clk), .in_restart_n(rst_n), .in_board(board), .in_send(send1), .in_auto(auto1),
        .out_busy(busy[0]), .out_sclk(sclk[0]), .out_sdata(sdata[0]), .out_latch(latch[0]), .out_done(done[0])
    );

    board_serializer #(.WIDTH(32), .CLK_DIV(4)) u4 (
        .in_clk(clk), .in_restart_n(rst_n), .in_board(board), .in_send(send4), .in_auto(auto4),
        .out_busy(busy[1]), .out_sclk(sclk[1]), .out_sdata(sdata[1]), .out_latch(latch[1]), .out_done(done[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model for both instances, sampled on the falling clk edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_clr) begin
                rx_word[i] <= '0; rise_cnt[i] <= 0; latch_cyc[i] <= 0; done_cnt[i] <= 0;
                busy_cyc[i] <= 0; viol[i] <= 0; latch_at[i] <= -1; done_at[i] <= -1;
                hi_len[i] <= 0; hi_min[i] <= 999; hi_max[i] <= 0;
                prev_sclk[i] <= 1'b0; prev_sdata[i] <= 1'b0; prev_latch[i] <= 1'b0;
            end else begin
                if (busy[i]) busy_cyc[i] <= busy_cyc[i] + 1;
                if (latch[i]) latch_cyc[i] <= latch_cyc[i] + 1;
                if (latch[i] && !prev_latch[i]) latch_at[i] <= cyc;
                if (done[i]) begin
                    done_cnt[i] <= done_cnt[i] + 1;
                    done_at[i]  <= cyc;
                end
                if (sclk[i] && !prev_sclk[i]) begin
                    rise_cnt[i] <= rise_cnt[i] + 1;
                    rx_word[i]  <= {rx_word[i][30:0], sdata[i]};
                end
                if ((sclk[i] && prev_sclk[i] && (sdata[i] != prev_sdata[i])) || (sclk[i] && latch[i]))
                    viol[i] <= viol[i] + 1;
                if (sclk[i]) begin
                    hi_len[i] <= hi_len[i] + 1;
                end else if (prev_sclk[i]) begin
                    if (hi_len[i] < hi_min[i]) hi_min[i] <= hi_len[i];
                    if (hi_len[i] > hi_max[i]) hi_max[i] <= hi_len[i];
                    hi_len[i] <= 0;
                end
                prev_sclk[i]  <= sclk[i];
                prev_sdata[i] <= sdata[i];
                prev_latch[i] <= latch[i];
            end
        end
    end

    task automatic clear_mon();
        @(negedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int n, input int bound, output bit got);
        got = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done_cnt[idx] >= n) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            board = $urandom; send1 = 1'($urandom_range(0, 1)); auto1 = 1'($urandom_range(0, 1));
            send4 = 1'($urandom_range(0, 1)); auto4 = 1'($urandom_range(0, 1));
            #1;
            for (int i = 0; i < 2; i++) begin
                cmp_cnt++;
                if ({busy[i], sclk[i], sdata[i], latch[i], done[i]} !== 5'b0) begin
                    err_cnt++;
                    $display("FAIL reset_outputs inst%0d: got %b expected 00000", i,
                             {busy[i], sclk[i], sdata[i], latch[i], done[i]});
                end
            end
        end
        @(negedge clk);
        board = 32'h0; send1 = 1'b0; auto1 = 1'b1; send4 = 1'b0; auto4 = 1'b0;
        rst_n = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        cmp_cnt++;
        if (busy_cyc[0] !== 0 || done_cnt[0] !== 0) begin
            err_cnt++;
            $display("FAIL reset_zero_board_auto: busy_cyc %0d done %0d expected 0 0", busy_cyc[0], done_cnt[0]);
        end
        auto1 = 1'b0;
    endtask

    task automatic test_basic_send();
        clear_mon();
        @(negedge clk); board = 32'hA5A50F0F; send1 = 1'b1; e0 = cyc + 1;
        @(negedge clk); send1 = 1'b0;
        wait_done(0, 1, 200, ok);
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL basic_timeout: got no done expected done"); end
        repeat (5) @(negedge clk);
        cmp_cnt++;
        if (rx_word[0] !== 32'hA5A50F0F) begin err_cnt++; $display("FAIL basic_data: got %h expected a5a50f0f", rx_word[0]); end
        cmp_cnt++;
        if (rise_cnt[0] !== 32) begin err_cnt++; $display("FAIL basic_rises: got %0d expected 32", rise_cnt[0]); end
        cmp_cnt++;
        if (latch_cyc[0] !== 1) begin err_cnt++; $display("FAIL basic_latch_width: got %0d expected 1", latch_cyc[0]); end
        cmp_cnt++;
        if (latch_at[0] !== e0 + 64) begin err_cnt++; $display("FAIL basic_latch_edge: got %0d expected %0d", latch_at[0], e0 + 64); end
        cmp_cnt++;
        if (done_at[0] !== e0 + 65) begin err_cnt++; $display("FAIL basic_done_edge: got %0d expected %0d", done_at[0], e0 + 65); end
        cmp_cnt++;
        if (busy_cyc[0] !== 65) begin err_cnt++; $display("FAIL basic_busy_len: got %0d expected 65", busy_cyc[0]); end
        cmp_cnt++;
        if (done_cnt[0] !== 1) begin err_cnt++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt[0]); end
        cmp_cnt++;
        if (viol[0] !== 0) begin err_cnt++; $display("FAIL basic_sdata_stable: got %0d expected 0", viol[0]); end
    endtask

    task automatic test_frozen_snapshot();
        clear_mon();
        @(negedge clk); board = 32'hFFFF0000; send1 = 1'b1;
        @(negedge clk); send1 = 1'b0;
        repeat (20) @(negedge clk);
        board = 32'h12345678; send1 = 1'b1;
        @(negedge clk); send1 = 1'b0;
        wait_done(0, 1, 200, ok);
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL frozen_timeout: got no done expected done"); end
        repeat (40) @(negedge clk);
        cmp_cnt++;
        if (rx_word[0] !== 32'hFFFF0000) begin err_cnt++; $display("FAIL frozen_data: got %h expected ffff0000", rx_word[0]); end
        cmp_cnt++;
        if (done_cnt[0] !== 1) begin err_cnt++; $display("FAIL frozen_done_count: got %0d expected 1", done_cnt[0]); end
    endtask

    task automatic test_auto_mode();
        clear_mon();
        @(negedge clk); auto1 = 1'b1; board = 32'h00000001;
        wait_done(0, 1, 200, ok);
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL auto_timeout: got no done expected done"); end
        repeat (1000) @(negedge clk);
        cmp_cnt++;
        if (done_cnt[0] !== 1) begin err_cnt++; $display("FAIL auto_hold_count: got %0d expected 1", done_cnt[0]); end
        cmp_cnt++;
        if (rx_word[0] !== 32'h00000001) begin err_cnt++; $display("FAIL auto_data: got %h expected 00000001", rx_word[0]); end
        clear_mon();
        @(negedge clk); board = 32'h0F0F0F0F;
        repeat (10) @(negedge clk);
        board = 32'hCAFEBABE;
        wait_done(0, 2, 400, ok);
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL auto_retrigger_timeout: got no second done expected two"); end
        repeat (200) @(negedge clk);
        cmp_cnt++;
        if (done_cnt[0] !== 2) begin err_cnt++; $display("FAIL auto_retrigger_count: got %0d expected 2", done_cnt[0]); end
        cmp_cnt++;
        if (rx_word[0] !== 32'hCAFEBABE) begin err_cnt++; $display("FAIL auto_retrigger_data: got %h expected cafebabe", rx_word[0]); end
        cmp_cnt++;
        if (rise_cnt[0] !== 64) begin err_cnt++; $display("FAIL auto_retrigger_rises: got %0d expected 64", rise_cnt[0]); end
        auto1 = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        clear_mon();
        @(negedge clk); board = 32'h13572468; send1 = 1'b1;
        @(negedge clk); send1 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rise_cnt[0] >= 10) begin ok = 1'b1; break; end
        end
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL midreset_reach_bit10: got %0d rises expected 10", rise_cnt[0]); end
        #1 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if ({busy[0], sclk[0], sdata[0], latch[0], done[0]} !== 5'b0) begin
            err_cnt++;
            $display("FAIL midreset_outputs: got %b expected 00000", {busy[0], sclk[0], sdata[0], latch[0], done[0]});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (100) @(negedge clk);
        cmp_cnt++;
        if (latch_cyc[0] !== 0 || done_cnt[0] !== 0) begin
            err_cnt++;
            $display("FAIL midreset_no_latch_done: latch %0d done %0d expected 0 0", latch_cyc[0], done_cnt[0]);
        end
        cmp_cnt++;
        if (busy[0] !== 1'b0) begin err_cnt++; $display("FAIL midreset_idle: got busy %b expected 0", busy[0]); end
    endtask

    task automatic test_default_timing();
        clear_mon();
        @(negedge clk); board = 32'h80000001; send4 = 1'b1; e0 = cyc + 1;
        @(negedge clk); send4 = 1'b0;
        wait_done(1, 1, 600, ok);
        cmp_cnt++;
        if (!ok) begin err_cnt++; $display("FAIL div4_timeout: got no done expected done"); end
        repeat (10) @(negedge clk);
        cmp_cnt++;
        if (busy_cyc[1] !== 260) begin err_cnt++; $display("FAIL div4_busy_len: got %0d expected 260", busy_cyc[1]); end
        cmp_cnt++;
        if (latch_cyc[1] !== 4) begin err_cnt++; $display("FAIL div4_latch_width: got %0d expected 4", latch_cyc[1]); end
        cmp_cnt++;
        if (latch_at[1] !== e0 + 256) begin err_cnt++; $display("FAIL div4_latch_edge: got %0d expected %0d", latch_at[1], e0 + 256); end
        cmp_cnt++;
        if (done_at[1] !== e0 + 260) begin err_cnt++; $display("FAIL div4_done_edge: got %0d expected %0d", done_at[1], e0 + 260); end
        cmp_cnt++;
        if (rx_word[1] !== 32'h80000001) begin err_cnt++; $display("FAIL div4_data: got %h expected 80000001", rx_word[1]); end
        cmp_cnt++;
        if (rise_cnt[1] !== 32) begin err_cnt++; $display("FAIL div4_rises: got %0d expected 32", rise_cnt[1]); end
        cmp_cnt++;
        if (hi_min[1] !== 4 || hi_max[1] !== 4) begin
            err_cnt++;
            $display("FAIL div4_half_period: got min %0d max %0d expected 4 4", hi_min[1], hi_max[1]);
        end
        cmp_cnt++;
        if (viol[1] !== 0) begin err_cnt++; $display("FAIL div4_sdata_stable: got %0d expected 0", viol[1]); end
    endtask

    initial begin
        rst_n = 1'b0; board = '0; send1 = 1'b0; auto1 = 1'b0; send4 = 1'b0; auto4 = 1'b0;
        test_reset();
        test_basic_send();
        test_frozen_snapshot();
        test_auto_mode();
        test_reset_mid_transfer();
        test_default_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
